lcd_timing_gen: RTL and testbench

- Parametrised LCD/VGA raster timing generator and pixel output stage; successor to the fixed-mode LCD driver under sdram_vga_ip/lcd_ip.
- Horizontal/vertical timing, sync polarity, data width and request lead time are parameters instead of a fixed mode table.
- Adds a run/stop control, a built-in test-pattern generator, and a pattern select that changes only on frame boundaries.
- Sits between the SDRAM read FIFO (user side) and the DAC/LCD panel pins.

---
 rtl/lcd_timing_gen.sv | 175 +++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised raster timing generator and pixel output
// stage. A single counter stage (h_cnt/v_cnt) feeds one register stage (_p0)
// that drives every panel pin except lcd_dclk and lcd_sync.
module lcd_timing_gen #(
  parameter int DATA_W   = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 1,
  parameter int CNT_W    = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_on,
  input  logic [1:0]        pat_sel,
  output logic              lcd_dclk,
  output logic              lcd_blank,
  output logic              lcd_sync,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_en,
  output logic [DATA_W-1:0] lcd_rgb,
  output logic              lcd_request,
  output logic              lcd_framesync,
  output logic [CNT_W-1:0]  lcd_xpos,
  output logic [CNT_W-1:0]  lcd_ypos,
  input  logic [DATA_W-1:0] lcd_data
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] H_REQ_S  = CNT_W'(H_SYNC + H_BP - REQ_LEAD);
  localparam logic [CNT_W-1:0] H_REQ_E  = CNT_W'(H_SYNC + H_BP + H_ACTIVE - REQ_LEAD);

  localparam logic [CNT_W+2:0] H_ACT_W3 = (CNT_W+3)'(H_ACTIVE);

  // Colour field split: RGB565 at 16 bits, equal thirds otherwise.
  localparam int B_W = DATA_W / 3;
  localparam int R_W = DATA_W / 3;
  localparam int G_W = DATA_W - 2 * (DATA_W / 3);

  generate
    if (REQ_LEAD < 1 || REQ_LEAD > H_BP) begin : g_bad_req_lead
      $error("lcd_timing_gen: REQ_LEAD must lie in 1..H_BP");
    end
  endgenerate

  // Eight equal-width vertical bars; bar index bits map to R, G, B.
  function automatic logic [DATA_W-1:0] bar_colour(input logic [CNT_W-1:0] x);
    logic [2:0] bar;
    bar = 3'({x, 3'b000} / H_ACT_W3);
    return {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}};
  endfunction

  // 16-pixel grid: white lines on every 16th column and row.
  function automatic logic [DATA_W-1:0] grid_colour(input logic [3:0] xl,
                                                    input logic [3:0] yl);
    return (xl == 4'd0 || yl == 4'd0) ? '1 : '0;
  endfunction

  function automatic logic [DATA_W-1:0] pix_select(input logic [1:0]        pat,
                                                   input logic [CNT_W-1:0]  x,
                                                   input logic [CNT_W-1:0]  y,
                                                   input logic [DATA_W-1:0] user);
    case (pat)
      2'd0:    return user;
      2'd1:    return bar_colour(x);
      2'd2:    return grid_colour(x[3:0], y[3:0]);
      default: return '1;
    endcase
  endfunction

  logic [CNT_W-1:0]  h_cnt, v_cnt;
  logic [1:0]        pat_q;
  logic              run;
  logic              h_act, v_act, h_req, act, req;
  logic              frame_start, h_wrap, v_wrap;
  logic [CNT_W-1:0]  x_act, y_act, x_req;
  logic [DATA_W-1:0] pix;

  logic              hs_p0, vs_p0, vld_p0, req_p0, fs_p0;
  logic [DATA_W-1:0] rgb_p0;
  logic [CNT_W-1:0]  xpos_p0, ypos_p0;

  // Reset takes priority, but both reset and stop collapse to the same idle.
  assign run         = rst_n & disp_on;

  assign h_wrap      = (h_cnt == H_MAX);
  assign v_wrap      = (v_cnt == V_MAX);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

  assign h_act = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
  assign v_act = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
  assign h_req = (h_cnt >= H_REQ_S) && (h_cnt < H_REQ_E);
  assign act   = h_act & v_act;
  assign req   = h_req & v_act;

  assign x_act = h_cnt - H_ACT_S;
  assign y_act = v_cnt - V_ACT_S;
  assign x_req = h_cnt - H_REQ_S;

  assign pix   = pix_select(pat_q, x_act, y_act, lcd_data);

  // Counter stage: raster position and frame-aligned pattern select.
  always_ff @(posedge clk) begin
    if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
      pat_q <= 2'd0;
    end else begin
      if (frame_start) pat_q <= pat_sel;
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + ONE;
      end else begin
        h_cnt <= h_cnt + ONE;
      end
    end
  end

  // Output stage p0, control: syncs, enable, request and frame pulse.
  always_ff @(posedge clk) begin
    if (!run) begin
      hs_p0  <= ~HS_POL;
      vs_p0  <= ~VS_POL;
      vld_p0 <= 1'b0;
      req_p0 <= 1'b0;
      fs_p0  <= 1'b0;
    end else begin
      hs_p0  <= (h_cnt < H_SYNC_E) ? HS_POL : ~HS_POL;
      vs_p0  <= (v_cnt < V_SYNC_E) ? VS_POL : ~VS_POL;
      vld_p0 <= act;
      req_p0 <= req;
      fs_p0  <= frame_start;
    end
  end

  // Output stage p0, data: pixel and coordinates, forced to zero outside
  // their windows rather than reset.
  always_ff @(posedge clk) begin
    rgb_p0  <= (run && act)   ? pix   : '0;
    xpos_p0 <= (run && req)   ? x_req : '0;
    ypos_p0 <= (run && v_act) ? y_act : '0;
  end

  assign lcd_dclk      = ~clk;
  assign lcd_sync      = 1'b0;
  assign lcd_hs        = hs_p0;
  assign lcd_vs        = vs_p0;
  assign lcd_en        = vld_p0;
  assign lcd_blank     = vld_p0;
  assign lcd_request   = req_p0;
  assign lcd_framesync = fs_p0;
  assign lcd_rgb       = rgb_p0;
  assign lcd_xpos      = xpos_p0;
  assign lcd_ypos      = ypos_p0;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: scoreboard bench for lcd_timing_gen in the small
// H 3/2/8/2, V 1/1/4/2 configuration.
`timescale 1ns/1ps
module tb_lcd_timing_gen;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 11;

  // Layout: 18'0, dclk, sync, fs, hs, vs, en, blank, req, xpos, ypos, rgb
  localparam logic [63:0] IDLE = {18'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                  1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 16'd0};

  logic              clk = 1'b0;
  logic              rst_n, disp_on;
  logic [1:0]        pat_sel;
  logic [DATA_W-1:0] lcd_data;
  logic              lcd_dclk, lcd_blank, lcd_sync, lcd_hs, lcd_vs, lcd_en;
  logic [DATA_W-1:0] lcd_rgb;
  logic              lcd_request, lcd_framesync;
  logic [CNT_W-1:0]  lcd_xpos, lcd_ypos;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .DATA_W(DATA_W), .H_SYNC(3), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .disp_on(disp_on), .pat_sel(pat_sel),
    .lcd_dclk(lcd_dclk), .lcd_blank(lcd_blank), .lcd_sync(lcd_sync),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_en(lcd_en), .lcd_rgb(lcd_rgb),
    .lcd_request(lcd_request), .lcd_framesync(lcd_framesync),
    .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos), .lcd_data(lcd_data)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference raster for the small configuration.
  function automatic logic [63:0] exp_vec(input int h, input int v, input logic [1:0] pq);
    logic        ha, va, en, req, fs, hs, vs;
    logic [15:0] rgb;
    logic [2:0]  b;
    logic [10:0] xp, yp;
    int          x, y;
    ha  = (h >= 5) && (h < 13);
    va  = (v >= 2) && (v < 6);
    en  = ha && va;
    req = (h >= 4) && (h < 12) && va;
    x   = h - 5;
    y   = v - 2;
    b   = 3'(x);
    rgb = 16'h0;
    if (en) begin
      case (pq)
        2'd0:    rgb = 16'h1000 + 16'(x);
        2'd1:    rgb = {{5{b[2]}}, {6{b[1]}}, {5{b[0]}}};
        2'd2:    rgb = ((x % 16) == 0 || (y % 16) == 0) ? 16'hFFFF : 16'h0;
        default: rgb = 16'hFFFF;
      endcase
    end
    xp = req ? 11'(h - 4) : 11'd0;
    yp = va ? 11'(y) : 11'd0;
    fs = (h == 0) && (v == 0);
    hs = (h >= 3);
    vs = (v >= 1);
    return {18'd0, 1'b0, 1'b0, fs, hs, vs, en, en, req, xp, yp, rgb};
  endfunction

  int          mh = 0, mv = 0;
  logic [1:0]  mpat = 2'd0;
  logic [63:0] sb[$];
  string       phase = "reset";

  int cnt_fs, cnt_en, cnt_req, cnt_hs_lo, cnt_vs_lo, cnt_lead_ok, cnt_white;
  int cnt_rgb_off = 0;
  logic prev_en = 1'b0, prev_req = 1'b0, req_rose_prev = 1'b0;

  logic [63:0] run0 [50];
  int cap_mode = 0;
  int cap_idx  = 0;

  task automatic clr_cnts();
    cnt_fs = 0; cnt_en = 0; cnt_req = 0; cnt_hs_lo = 0; cnt_vs_lo = 0;
    cnt_lead_ok = 0; cnt_white = 0;
  endtask

  task automatic cycle(input logic rv, input logic dv, input logic [1:0] pv);
    logic [63:0] e, o;
    logic        en_rise;
    @(negedge clk);
    rst_n    = rv;
    disp_on  = dv;
    pat_sel  = pv;
    lcd_data = 16'h1000 + 16'(lcd_xpos);
    if (!rv || !dv) begin
      e = IDLE; mh = 0; mv = 0; mpat = 2'd0;
    end else begin
      e = exp_vec(mh, mv, mpat);
      if (mh == 0 && mv == 0) mpat = pv;
      if (mh == 14) begin
        mh = 0;
        mv = (mv == 7) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = {18'd0, lcd_dclk, lcd_sync, lcd_framesync, lcd_hs, lcd_vs, lcd_en,
         lcd_blank, lcd_request, lcd_xpos, lcd_ypos, lcd_rgb};
    e = sb.pop_front();
    chk(phase, o, e);
    if (lcd_framesync) cnt_fs++;
    if (lcd_en) cnt_en++;
    if (lcd_request) cnt_req++;
    if (!lcd_hs) cnt_hs_lo++;
    if (!lcd_vs) cnt_vs_lo++;
    if (lcd_en && lcd_rgb == 16'hFFFF) cnt_white++;
    if (!lcd_en && lcd_rgb != 16'h0) cnt_rgb_off++;
    en_rise = lcd_en && !prev_en;
    if (en_rise && req_rose_prev) cnt_lead_ok++;
    req_rose_prev = lcd_request && !prev_req;
    prev_en  = lcd_en;
    prev_req = lcd_request;
    if (cap_mode == 1 && cap_idx < 50) begin
      run0[cap_idx] = o;
      cap_idx++;
    end else if (cap_mode == 2 && cap_idx < 50) begin
      chk("restart", o, run0[cap_idx]);
      cap_idx++;
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; disp_on = 1'b0; pat_sel = 2'd0; lcd_data = '0;
    clr_cnts();

    phase = "reset";
    repeat (3) cycle(1'b0, 1'b0, 2'd0);
    phase = "idle";
    repeat (2) cycle(1'b1, 1'b0, 2'd0);

    // Two full frames of user data from a clean start.
    phase = "run";
    clr_cnts();
    cap_mode = 1; cap_idx = 0;
    repeat (240) cycle(1'b1, 1'b1, 2'd0);
    cap_mode = 0;
    chk("framesync_cnt", 64'(cnt_fs), 64'd2);
    chk("en_cnt", 64'(cnt_en), 64'd64);
    chk("req_cnt", 64'(cnt_req), 64'd64);
    chk("hs_low_cnt", 64'(cnt_hs_lo), 64'd48);
    chk("vs_low_cnt", 64'(cnt_vs_lo), 64'd30);
    chk("req_lead", 64'(cnt_lead_ok), 64'd8);

    // Pattern select changed mid-frame takes effect only next frame.
    phase = "patchg";
    repeat (60) cycle(1'b1, 1'b1, 2'd0);
    clr_cnts();
    repeat (60) cycle(1'b1, 1'b1, 2'd3);
    chk("white_midframe", 64'(cnt_white), 64'd0);
    phase = "white";
    clr_cnts();
    repeat (120) cycle(1'b1, 1'b1, 2'd3);
    chk("white_px", 64'(cnt_white), 64'd32);

    phase = "bars";
    repeat (120) cycle(1'b1, 1'b1, 2'd1);
    phase = "grid";
    repeat (120) cycle(1'b1, 1'b1, 2'd2);
    phase = "user2";
    repeat (30) cycle(1'b1, 1'b1, 2'd0);

    // Stop mid-frame at h_cnt = 9, then restart.
    phase = "seek_stop";
    guard = 0;
    while (mh != 9 && guard < 200) begin
      cycle(1'b1, 1'b1, 2'd0);
      guard++;
    end
    chk("seek_h9", 64'(mh), 64'd9);
    phase = "stop";
    repeat (3) cycle(1'b1, 1'b0, 2'd0);
    phase = "restart_on";
    cap_mode = 2; cap_idx = 0;
    repeat (130) cycle(1'b1, 1'b1, 2'd0);
    cap_mode = 0;

    // One-cycle reset in the middle of an active pixel.
    phase = "seek_rst";
    guard = 0;
    while (!(mh == 7 && mv == 3) && guard < 200) begin
      cycle(1'b1, 1'b1, 2'd0);
      guard++;
    end
    chk("seek_px", 64'({mv[7:0], mh[7:0]}), 64'h0307);
    phase = "rst_pulse";
    cycle(1'b0, 1'b1, 2'd0);
    phase = "restart_rst";
    cap_mode = 2; cap_idx = 0;
    repeat (130) cycle(1'b1, 1'b1, 2'd0);
    cap_mode = 0;

    chk("rgb_zero_off", 64'(cnt_rgb_off), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
